xband_frame_ctrl: RTL and testbench

Sequencer for the Xband link datapath, in the sys_clk domain. It takes a software-programmed frame job (byte count, frame count, timeout, loopback mode) and drives the link's xband reset request, new_frame strobe, expBytes and loopback controls. It monitors the link's received-byte counter and FIFO overflow flags. It reports per-frame completion, aggregate status and sticky errors to the register block.

---
 rtl/xband_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_xband_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xband_frame_ctrl.sv
// Xband link frame sequencer: link reset, per-frame new_frame strobe, byte-count
// completion, timeout/overflow/abort handling and sticky error reporting.
module xband_frame_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int NF_CYCLES     = 8,
    parameter int SETTLE_CYCLES = 64,
    parameter int GAP_CYCLES    = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_expBytes,
    input  logic [15:0] cfg_frames,
    input  logic [31:0] cfg_timeout,
    input  logic [1:0]  cfg_loopback,
    input  logic [31:0] dataCnt,
    input  logic        MM2S_overflow,
    input  logic        S2MM_overflow,
    output logic        xband_rst_req,
    output logic        new_frame,
    output logic [31:0] expBytes,
    output logic [1:0]  loopback,
    output logic        busy,
    output logic        frame_done,
    output logic        job_done,
    output logic [15:0] frame_cnt,
    output logic        err_overflow,
    output logic        err_timeout,
    output logic        err_cfg
);
    typedef enum logic [2:0] {IDLE, RST, ARM, SETTLE, WAIT, GAP, ERR} state_t;

    localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] NF_LAST     = 32'(NF_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    // The frame_done cycle sits in GAP ahead of the GAP_CYCLES idle window.
    localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES);

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [15:0] frames_r;
    logic [31:0] timeout_r;
    logic [15:0] fcnt_inc, fcnt_n;
    logic        accept, set_cfg, set_ovf, set_tmo, fdone_n, jdone_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 32'd1;
        fcnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
        fcnt_n   = frame_cnt;
        accept   = 1'b0;
        set_cfg  = 1'b0;
        set_ovf  = 1'b0;
        set_tmo  = 1'b0;
        fdone_n  = 1'b0;
        jdone_n  = 1'b0;
        if (state == IDLE) begin
            cnt_n = '0;
            if (start) begin
                if (cfg_expBytes == '0) begin
                    set_cfg = 1'b1;
                end else begin
                    accept  = 1'b1;
                    state_n = RST;
                end
            end
        end else if (abort) begin
            state_n = ERR;
            cnt_n   = '0;
        end else if (MM2S_overflow || S2MM_overflow) begin
            set_ovf = 1'b1;
            state_n = ERR;
            cnt_n   = '0;
        end else begin
            case (state)
                RST: if (cnt == RST_LAST) begin
                    state_n = ARM;
                    cnt_n   = '0;
                end
                ARM: if (cnt == NF_LAST) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
                SETTLE: if (cnt == SETTLE_LAST) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
                WAIT: begin
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (dataCnt >= expBytes) begin
                        fdone_n = 1'b1;
                        fcnt_n  = fcnt_inc;
                        cnt_n   = '0;
                        if (frames_r != '0 && fcnt_inc == frames_r) begin
                            jdone_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = GAP;
                        end
                    end else if (timeout_r != '0 && cnt == timeout_r - 32'd1) begin
                        set_tmo = 1'b1;
                        state_n = ERR;
                        cnt_n   = '0;
                    end
                end
                GAP: if (cnt == GAP_LAST) begin
                    state_n = ARM;
                    cnt_n   = '0;
                end
                ERR: if (cnt == RST_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            frames_r      <= '0;
            timeout_r     <= '0;
            xband_rst_req <= 1'b1;
            new_frame     <= 1'b0;
            expBytes      <= '0;
            loopback      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            job_done      <= 1'b0;
            frame_cnt     <= '0;
            err_overflow  <= 1'b0;
            err_timeout   <= 1'b0;
            err_cfg       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            // Outputs decode the next state so they line up with the state they describe.
            xband_rst_req <= (state_n == RST) || (state_n == ERR);
            new_frame     <= (state_n == ARM);
            busy          <= (state_n != IDLE);
            frame_done    <= fdone_n;
            job_done      <= jdone_n;
            frame_cnt     <= fcnt_n;
            if (accept) begin
                expBytes     <= cfg_expBytes;
                loopback     <= cfg_loopback;
                frames_r     <= cfg_frames;
                timeout_r    <= cfg_timeout;
                frame_cnt    <= '0;
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
                err_cfg      <= 1'b0;
            end
            if (set_cfg) err_cfg      <= 1'b1;
            if (set_ovf) err_overflow <= 1'b1;
            if (set_tmo) err_timeout  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_xband_frame_ctrl.sv
// Event scoreboard bench for xband_frame_ctrl: a timeline model predicts output events per job.
module tb_xband_frame_ctrl;
    localparam int RSTC = 16, NFC = 8, STC = 64, GPC = 32;
    localparam int K_BUSY_R = 0, K_BUSY_F = 1, K_RST_R = 2, K_RST_F = 3, K_NF_R = 4, K_NF_F = 5;
    localparam int K_FDONE = 6, K_JDONE = 7, K_ETMO = 8, K_EOVF = 9, K_ECFG = 10, K_ECLR = 11, NK = 12;

    logic        sys_clk = 1'b0, sys_rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] cfg_expBytes = '0, cfg_timeout = '0, dataCnt = '0;
    logic [15:0] cfg_frames = '0;
    logic [1:0]  cfg_loopback = '0;
    logic        MM2S_overflow = 1'b0, S2MM_overflow = 1'b0;
    logic        xband_rst_req, new_frame, busy, frame_done, job_done;
    logic [31:0] expBytes;
    logic [1:0]  loopback;
    logic [15:0] frame_cnt;
    logic        err_overflow, err_timeout, err_cfg;

    xband_frame_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
        .cfg_expBytes(cfg_expBytes), .cfg_frames(cfg_frames), .cfg_timeout(cfg_timeout),
        .cfg_loopback(cfg_loopback), .dataCnt(dataCnt), .MM2S_overflow(MM2S_overflow),
        .S2MM_overflow(S2MM_overflow), .xband_rst_req(xband_rst_req), .new_frame(new_frame),
        .expBytes(expBytes), .loopback(loopback), .busy(busy), .frame_done(frame_done),
        .job_done(job_done), .frame_cnt(frame_cnt), .err_overflow(err_overflow),
        .err_timeout(err_timeout), .err_cfg(err_cfg)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int    n_tests = 0, n_fail = 0;
    bit    mon_en = 1'b0;
    int    q_cyc[NK][$];
    int    q_val[NK][$];
    string kname[NK] = '{"busy_rise", "busy_fall", "rst_rise", "rst_fall", "nf_rise", "nf_fall",
                         "frame_done", "job_done", "err_timeout", "err_overflow", "err_cfg", "err_clear"};
    bit    m_eo = 0, m_et = 0, m_ec = 0;
    int    m_fcnt = 0;
    int    dly[8];

    task automatic push(input int k, input int c, input int v = 0);
        q_cyc[k].push_back(c);
        q_val[k].push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    task automatic see(input int k, input int v);
        int ec, ev;
        n_tests++;
        if (q_cyc[k].size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event at cycle %0d val %0d", kname[k], cyc, v);
        end else begin
            ec = q_cyc[k].pop_front();
            ev = q_val[k].pop_front();
            if (ec != cyc || ev != v) begin
                n_fail++;
                $display("FAIL %s: got cycle %0d val %0d, expected cycle %0d val %0d",
                         kname[k], cyc, v, ec, ev);
            end
        end
    endtask

    // Any expected event still queued once its cycle has passed was never produced.
    task automatic drain_check();
        for (int k = 0; k < NK; k++) begin
            while (q_cyc[k].size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: missing event expected at cycle %0d val %0d",
                         kname[k], q_cyc[k][0], q_val[k][0]);
                void'(q_cyc[k].pop_front());
                void'(q_val[k].pop_front());
            end
        end
    endtask

    initial begin : monitor
        logic p_busy, p_rst, p_nf, p_eo, p_et, p_ec;
        p_busy = 0; p_rst = 1; p_nf = 0; p_eo = 0; p_et = 0; p_ec = 0;
        forever begin
            @(negedge sys_clk);
            if (mon_en) begin
                if (busy && !p_busy) see(K_BUSY_R, 0);
                if (!busy && p_busy) see(K_BUSY_F, 0);
                if (xband_rst_req && !p_rst) see(K_RST_R, 0);
                if (!xband_rst_req && p_rst) see(K_RST_F, 0);
                if (new_frame && !p_nf) see(K_NF_R, 0);
                if (!new_frame && p_nf) see(K_NF_F, 0);
                if (frame_done) see(K_FDONE, int'(frame_cnt));
                if (job_done) see(K_JDONE, 0);
                if (err_timeout && !p_et) see(K_ETMO, 0);
                if (err_overflow && !p_eo) see(K_EOVF, 0);
                if (err_cfg && !p_ec) see(K_ECFG, 0);
                if ((p_eo && !err_overflow) || (p_et && !err_timeout) || (p_ec && !err_cfg))
                    see(K_ECLR, 0);
            end
            p_busy = busy; p_rst = xband_rst_req; p_nf = new_frame;
            p_eo = err_overflow; p_et = err_timeout; p_ec = err_cfg;
        end
    end

    function automatic logic [31:0] lt_val(input logic [31:0] e);
        return (e == 32'd1) ? 32'd0 : $urandom_range(e - 32'd1, 0);
    endfunction

    function automatic logic [31:0] ge_val(input logic [31:0] e);
        case ($urandom_range(2, 0))
            0:       return e;
            1:       return 32'hFFFF_FFFF;
            default: return (e > 32'hFFFF_0000) ? e : e + $urandom_range(1000, 1);
        endcase
    endfunction

    // mode: 0 run to completion/timeout, 1 overflow at WAIT offset 'off' of the last planned
    // frame (coinc: dataCnt also reaches expBytes then), 2 abort 'off' cycles into the GAP
    // after the last planned frame, 3 async reset two cycles into ARM of the last planned frame.
    task automatic run_job(input logic [31:0] ex, input logic [15:0] frames, input logic [31:0] to,
                           input logic [1:0] lb, input int nf, input int mode, input int off,
                           input bit coinc);
        int T, a, e, w, end_c, ovf_c, abt_c, rst_c, nplan;
        int e_a[8], wl_a[8];
        bit hit_a[8];
        bit dead;
        ovf_c = -1; abt_c = -1; rst_c = -1; nplan = 0; dead = 0;
        @(negedge sys_clk);
        T = cyc;
        push(K_BUSY_R, T + 1);
        push(K_RST_R, T + 1);
        push(K_RST_F, T + RSTC + 1);
        if (m_eo || m_et || m_ec) push(K_ECLR, T + 1);
        m_eo = 0; m_et = 0; m_ec = 0; m_fcnt = 0;
        a = T + RSTC + 1;
        end_c = a;
        for (int i = 0; i < nf && !dead; i++) begin
            push(K_NF_R, a);
            if (mode == 3 && i == nf - 1) begin
                rst_c = a + 2; end_c = rst_c; dead = 1;
            end else begin
                push(K_NF_F, a + NFC);
                e = a + NFC + STC;
                e_a[i] = e;
                nplan = i + 1;
                if (mode == 1 && i == nf - 1) begin
                    ovf_c = e + off; wl_a[i] = ovf_c; hit_a[i] = coinc;
                    m_eo = 1;
                    push(K_EOVF, ovf_c + 1);
                    push(K_RST_R, ovf_c + 1);
                    push(K_RST_F, ovf_c + 1 + RSTC);
                    push(K_BUSY_F, ovf_c + 1 + RSTC);
                    end_c = ovf_c + 1 + RSTC; dead = 1;
                end else if (to != 0 && dly[i] >= int'(to)) begin
                    wl_a[i] = e + int'(to) - 1; hit_a[i] = 0;
                    m_et = 1;
                    push(K_ETMO, e + int'(to));
                    push(K_RST_R, e + int'(to));
                    push(K_RST_F, e + int'(to) + RSTC);
                    push(K_BUSY_F, e + int'(to) + RSTC);
                    end_c = e + int'(to) + RSTC; dead = 1;
                end else begin
                    w = e + dly[i]; wl_a[i] = w; hit_a[i] = 1;
                    m_fcnt++;
                    push(K_FDONE, w + 1, m_fcnt);
                    if (frames != 0 && m_fcnt == int'(frames)) begin
                        push(K_JDONE, w + 1);
                        push(K_BUSY_F, w + 1);
                        end_c = w + 1; dead = 1;
                    end else if (mode == 2 && i == nf - 1) begin
                        abt_c = w + 1 + off;
                        push(K_RST_R, abt_c + 1);
                        push(K_RST_F, abt_c + 1 + RSTC);
                        push(K_BUSY_F, abt_c + 1 + RSTC);
                        end_c = abt_c + 1 + RSTC; dead = 1;
                    end else begin
                        a = w + GPC + 2; end_c = a;
                    end
                end
            end
        end

        for (int c = T; c <= end_c + 4; c++) begin
            if (c != T) @(negedge sys_clk);
            start         = (c == T) || (c == T + 2);
            abort         = (c == abt_c) || (c == end_c + 1);
            MM2S_overflow = (c == ovf_c && off[0]) || (c == end_c + 2);
            S2MM_overflow = (c == ovf_c && !off[0]) || (c == end_c + 3);
            if (c == T) begin
                cfg_expBytes = ex; cfg_frames = frames; cfg_timeout = to; cfg_loopback = lb;
            end else begin
                cfg_expBytes = (c == T + 2 && $urandom_range(1, 0) == 1) ? 32'd0 : $urandom();
                cfg_frames   = 16'($urandom());
                cfg_timeout  = $urandom();
                cfg_loopback = 2'($urandom());
            end
            dataCnt = $urandom();
            for (int i = 0; i < nplan; i++)
                if (c >= e_a[i] && c <= wl_a[i])
                    dataCnt = (c == wl_a[i] && hit_a[i]) ? ge_val(ex) : lt_val(ex);
            if (c == rst_c) begin
                mon_en = 0;
                #2 sys_rst = 1'b1;
                #1;
                check("rst_mid_new_frame", {31'd0, new_frame}, 32'd0);
                check("rst_mid_rst_req", {31'd0, xband_rst_req}, 32'd1);
                check("rst_mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
                check("rst_mid_busy", {31'd0, busy}, 32'd0);
                drain_check();
                m_fcnt = 0; m_eo = 0; m_et = 0; m_ec = 0;
                start = 0; abort = 0; MM2S_overflow = 0; S2MM_overflow = 0;
                repeat (2) @(negedge sys_clk);
                sys_rst = 1'b0;
                repeat (2) @(negedge sys_clk);
                mon_en = 1;
                break;
            end
        end
        drain_check();
        check("job_frame_cnt", {16'd0, frame_cnt}, m_fcnt);
        check("job_busy", {31'd0, busy}, 32'd0);
        check("job_err_overflow", {31'd0, err_overflow}, {31'd0, m_eo});
        check("job_err_timeout", {31'd0, err_timeout}, {31'd0, m_et});
        check("job_err_cfg", {31'd0, err_cfg}, {31'd0, m_ec});
        check("job_expBytes", expBytes, (mode == 3) ? 32'd0 : ex);
        check("job_loopback", {30'd0, loopback}, (mode == 3) ? 32'd0 : {30'd0, lb});
    endtask

    task automatic bad_start();
        @(negedge sys_clk);
        cfg_expBytes = 32'd0; cfg_frames = 16'($urandom()); cfg_timeout = $urandom(); start = 1'b1;
        if (!m_ec) push(K_ECFG, cyc + 1);
        m_ec = 1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        drain_check();
        check("badcfg_busy", {31'd0, busy}, 32'd0);
        check("badcfg_err_cfg", {31'd0, err_cfg}, 32'd1);
        check("badcfg_frame_cnt", {16'd0, frame_cnt}, m_fcnt);
    endtask

    initial begin
        logic [31:0] ex, to;
        logic [15:0] fr;
        int nf, mode, off;
        repeat (3) @(negedge sys_clk);
        check("reset_rst_req", {31'd0, xband_rst_req}, 32'd1);
        check("reset_new_frame", {31'd0, new_frame}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_expBytes", expBytes, 32'd0);
        check("reset_loopback", {30'd0, loopback}, 32'd0);
        check("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("reset_pulses", {30'd0, frame_done, job_done}, 32'd0);
        check("reset_errs", {29'd0, err_overflow, err_timeout, err_cfg}, 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("release_rst_req", {31'd0, xband_rst_req}, 32'd0);
        mon_en = 1;

        dly[0] = 20;                                    run_job(256, 1, 0, 2'd1, 1, 0, 0, 0);
        dly[0] = 10; dly[1] = 0; dly[2] = 37;           run_job(256, 3, 0, 2'd2, 3, 0, 0, 0);
        dly[0] = 1000;                                  run_job(500, 1, 100, 2'd3, 1, 0, 0, 0);
        dly[0] = 99;                                    run_job(500, 1, 100, 2'd0, 1, 0, 0, 0);
        dly[0] = 5;                                     run_job(256, 2, 0, 2'd1, 2, 1, 14, 1);
        dly[0] = 3; dly[1] = 12;                        run_job(300, 0, 0, 2'd2, 2, 2, 5, 0);
        dly[0] = 0;                                     run_job(32'hFFFF_FFFF, 1, 0, 2'd3, 1, 0, 0, 0);
        bad_start();
        bad_start();
        dly[0] = 7;                                     run_job(1, 1, 0, 2'd1, 1, 0, 0, 0);
        dly[0] = 5;                                     run_job(100, 3, 0, 2'd2, 2, 3, 0, 0);

        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(3, 0))
                0:       ex = 32'd1;
                1:       ex = 32'hFFFF_FFFF;
                default: ex = $urandom_range(2000, 1);
            endcase
            to   = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(200, 20)) : 32'd0;
            nf   = $urandom_range(3, 1);
            mode = $urandom_range(2, 0);
            fr   = (mode == 2) ? 16'd0 : 16'(nf);
            off  = (mode == 2) ? $urandom_range(GPC, 0)
                 : (to != 0) ? $urandom_range(int'(to) - 1, 0) : $urandom_range(60, 0);
            for (int i = 0; i < 8; i++) dly[i] = $urandom_range(150, 0);
            run_job(ex, fr, to, 2'($urandom()), nf, mode, off, 1'($urandom()));
        end

        repeat (5) @(negedge sys_clk);
        drain_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
